// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the CC_PLL reset sequencer: state encodings,
// 10 MHz default timing and the per-state output decode.
package pll_ctrl_pkg;

    localparam logic [2:0] ST_RESET     = 3'd0;
    localparam logic [2:0] ST_STDY_RST  = 3'd1;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
    localparam logic [2:0] ST_SETTLE    = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_LOST      = 3'd5;
    localparam logic [2:0] ST_FAIL      = 3'd6;

    // Defaults for a 10 MHz reference clock.
    localparam int DEF_LOCK_TIMEOUT = 10000;
    localparam int DEF_SETTLE_CYC   = 1000;
    localparam int DEF_STDY_RST_CYC = 4;
    localparam int DEF_MAX_RETRY    = 3;
    localparam int DEF_CNT_W        = 16;

    typedef struct packed {
        logic pll_stdy_rst;
        logic core_reset;
        logic ready;
        logic fail;
    } ctrl_out_t;

    // Moore output decode; the top registers the result for the state being entered.
    function automatic ctrl_out_t state_outputs(input logic [2:0] st);
        ctrl_out_t o;
        o.pll_stdy_rst = (st == ST_RESET) || (st == ST_STDY_RST);
        o.core_reset   = (st != ST_RUN);
        o.ready        = (st == ST_RUN);
        o.fail         = (st == ST_FAIL);
        return o;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for slow-changing level signals crossing
// into the local clock domain; clears to zero on reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL lock supervisor on the reference clock: pulses the lock-steady detector
// reset, waits for a stable lock, then releases the core reset.
module pll_rst_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int STDY_RST_CYC = DEF_STDY_RST_CYC,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       pll_locked_stdy,
    output logic       pll_stdy_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       fail,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]   STDY_LAST    = CNT_W'(STDY_RST_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY - 1);

    if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT >= (1 << CNT_W)) begin : g_bad_lock_timeout
        $error("pll_rst_ctrl: LOCK_TIMEOUT must be in [1, 2**CNT_W)");
    end
    if (SETTLE_CYC < 1 || SETTLE_CYC >= (1 << CNT_W)) begin : g_bad_settle_cyc
        $error("pll_rst_ctrl: SETTLE_CYC must be in [1, 2**CNT_W)");
    end
    if (STDY_RST_CYC < 1 || STDY_RST_CYC >= (1 << CNT_W)) begin : g_bad_stdy_rst_cyc
        $error("pll_rst_ctrl: STDY_RST_CYC must be in [1, 2**CNT_W)");
    end
    if (MAX_RETRY < 1) begin : g_bad_max_retry
        $error("pll_rst_ctrl: MAX_RETRY must be at least 1");
    end

    logic [1:0]         lock_sync;
    logic               lk;
    logic               lks;
    logic               lock_ok;
    logic [CNT_W-1:0]   timer;
    logic [CNT_W-1:0]   timer_n;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_n;
    logic [2:0]         state_n;
    logic [7:0]         loss_n;
    ctrl_out_t          out_q;
    ctrl_out_t          out_n;

    sync2 #(
        .WIDTH (2)
    ) u_lock_sync (
        .clk (pclk),
        .rst (reset),
        .d   ({pll_locked_stdy, pll_locked}),
        .q   (lock_sync)
    );

    assign lk      = lock_sync[0];
    assign lks     = lock_sync[1];
    assign lock_ok = lk & lks;

    always_comb begin
        state_n = state;
        timer_n = timer;
        retry_n = retry;
        loss_n  = loss_cnt;
        case (state)
            ST_RESET: begin
                state_n = ST_STDY_RST;
                timer_n = '0;
            end
            ST_STDY_RST: begin
                if (timer == STDY_LAST) begin
                    state_n = ST_WAIT_LOCK;
                    timer_n = '0;
                end else begin
                    timer_n = timer + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is checked before the timeout so a late lock still wins.
                if (lock_ok) begin
                    state_n = ST_SETTLE;
                    timer_n = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    retry_n = retry + RETRY_W'(1);
                    timer_n = '0;
                    state_n = (retry == RETRY_LAST) ? ST_FAIL : ST_STDY_RST;
                end else begin
                    timer_n = timer + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (!lock_ok) begin
                    state_n = ST_WAIT_LOCK;
                    timer_n = '0;
                end else if (timer == SETTLE_LAST) begin
                    state_n = ST_RUN;
                    timer_n = '0;
                    retry_n = '0;
                end else begin
                    timer_n = timer + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_ok) begin
                    state_n = ST_LOST;
                    loss_n  = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
                end
            end
            ST_LOST: begin
                state_n = ST_STDY_RST;
                timer_n = '0;
            end
            ST_FAIL: begin
                state_n = ST_FAIL;
            end
            default: begin
                state_n = ST_RESET;
                timer_n = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with `state`.
    assign out_n = state_outputs(state_n);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state    <= ST_RESET;
            timer    <= '0;
            retry    <= '0;
            loss_cnt <= 8'd0;
            out_q    <= state_outputs(ST_RESET);
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            retry    <= retry_n;
            loss_cnt <= loss_n;
            out_q    <= out_n;
        end
    end

    assign pll_stdy_rst = out_q.pll_stdy_rst;
    assign core_reset   = out_q.core_reset;
    assign ready        = out_q.ready;
    assign fail         = out_q.fail;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Bench for pll_rst_ctrl: per-cycle expected output words are queued as the
// lock inputs are scripted and compared on the falling edge.
module tb_pll_rst_ctrl;

    localparam int LOCK_TIMEOUT = 20;
    localparam int SETTLE_CYC   = 8;
    localparam int STDY_RST_CYC = 4;
    localparam int MAX_RETRY    = 3;
    localparam int W            = 15;

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_STDY   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_LOST   = 3'd5;
    localparam logic [2:0] S_FAIL   = 3'd6;

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_locked_stdy = 1'b0;
    logic       pll_stdy_rst;
    logic       core_reset;
    logic       ready;
    logic       fail;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    logic [W-1:0] obs;
    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // ---- clock / reset ----
    always #5 pclk = ~pclk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, required finish before t=400000");
        $fatal(1, "watchdog expired");
    end

    pll_rst_ctrl #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .SETTLE_CYC   (SETTLE_CYC),
        .STDY_RST_CYC (STDY_RST_CYC),
        .MAX_RETRY    (MAX_RETRY),
        .CNT_W        (16)
    ) dut (
        .pclk            (pclk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .pll_locked_stdy (pll_locked_stdy),
        .pll_stdy_rst    (pll_stdy_rst),
        .core_reset      (core_reset),
        .ready           (ready),
        .fail            (fail),
        .loss_cnt        (loss_cnt),
        .state           (state)
    );

    assign obs = {state, pll_stdy_rst, core_reset, ready, fail, loss_cnt};

    // Expected outputs for a given state, straight from the state table.
    function automatic logic [W-1:0] exp_word(input logic [2:0] st, input logic [7:0] loss);
        logic stdy;
        logic crst;
        logic rdy;
        logic fl;
        stdy = (st == S_RESET) || (st == S_STDY);
        crst = (st != S_RUN);
        rdy  = (st == S_RUN);
        fl   = (st == S_FAIL);
        return {st, stdy, crst, rdy, fl, loss};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s (vector %0d): observed %h, expected %h", tag, vectors, got, exp);
        end
    endtask

    // ---- driver tasks ----
    task automatic step();
        @(negedge pclk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [2:0] st, input int n, input logic [7:0] loss);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_word(st, loss));
    endtask

    task automatic set_locks(input logic lk, input logic lks);
        pll_locked      = lk;
        pll_locked_stdy = lks;
    endtask

    // ---- scoreboard: one queued word per clock after each rising edge ----
    always @(negedge pclk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("trace", 32'(obs), 32'(e));
        end
    end

    // ---- stimulus ----
    initial begin
        int dwell;
        int sel;
        logic [7:0] prev;
        logic [7:0] nxt;

        step_n(3);
        check("reset_values", 32'(obs), 32'(exp_word(S_RESET, 8'd0)));

        // Normal bring-up: locks rise after edge 10, SETTLE at 13, RUN at 21.
        reset = 1'b0;
        push(S_STDY, 4, 8'd0);
        push(S_WAIT, 8, 8'd0);
        push(S_SETTLE, 8, 8'd0);
        push(S_RUN, 3, 8'd0);
        for (int k = 1; k <= 23; k++) begin
            step();
            if (k == 10) set_locks(1'b1, 1'b1);
        end

        // Lock loss in RUN, then a one-cycle glitch at SETTLE timer=5.
        push(S_RUN, 2, 8'd0);
        push(S_LOST, 1, 8'd1);
        push(S_STDY, 4, 8'd1);
        push(S_WAIT, 3, 8'd1);
        push(S_SETTLE, 6, 8'd1);
        push(S_WAIT, 1, 8'd1);
        push(S_SETTLE, 8, 8'd1);
        push(S_RUN, 2, 8'd1);
        set_locks(1'b1, 1'b0);
        step_n(8);
        set_locks(1'b1, 1'b1);
        step_n(6);
        sel = $urandom_range(0, 1);
        if (sel == 0) set_locks(1'b0, 1'b1);
        else          set_locks(1'b1, 1'b0);
        step_n(1);
        set_locks(1'b1, 1'b1);
        step_n(12);

        // Timeouts: lock first seen at timer==19, a settle drop, then FAIL.
        push(S_RUN, 2, 8'd1);
        push(S_LOST, 1, 8'd2);
        push(S_STDY, 4, 8'd2);
        push(S_WAIT, 20, 8'd2);
        push(S_STDY, 4, 8'd2);
        push(S_WAIT, 20, 8'd2);
        push(S_SETTLE, 3, 8'd2);
        push(S_WAIT, 20, 8'd2);
        push(S_STDY, 4, 8'd2);
        push(S_WAIT, 20, 8'd2);
        push(S_FAIL, 1000, 8'd2);
        set_locks(1'b0, 1'b0);
        step_n(49);
        set_locks(1'b1, 1'b1);
        step_n(3);
        set_locks(1'b0, 1'b0);
        step_n(1046);

        // FAIL only leaves through reset.
        reset = 1'b1;
        #1;
        check("fail_async_reset", 32'(obs), 32'(exp_word(S_RESET, 8'd0)));
        set_locks(1'b1, 1'b1);
        step_n(2);
        reset = 1'b0;
        push(S_STDY, 4, 8'd0);
        push(S_WAIT, 1, 8'd0);
        push(S_SETTLE, 8, 8'd0);
        push(S_RUN, 1, 8'd0);
        step_n(14);

        // 256 losses: loss_cnt climbs to 255 and holds there.
        for (int i = 0; i < 256; i++) begin
            prev  = (i >= 255) ? 8'd255 : 8'(i);
            nxt   = (i + 1 >= 255) ? 8'd255 : 8'(i + 1);
            dwell = $urandom_range(0, 3);
            push(S_RUN, dwell, prev);
            step_n(dwell);
            push(S_RUN, 2, prev);
            push(S_LOST, 1, nxt);
            push(S_STDY, 4, nxt);
            push(S_WAIT, 1, nxt);
            push(S_SETTLE, 8, nxt);
            push(S_RUN, 1, nxt);
            sel = $urandom_range(0, 1);
            if (sel == 0) set_locks(1'b0, 1'b1);
            else          set_locks(1'b1, 1'b0);
            step_n(3);
            set_locks(1'b1, 1'b1);
            step_n(14);
        end
        check("loss_saturated", 32'(loss_cnt), 32'd255);

        // Asynchronous reset in RUN, between clock edges.
        @(posedge pclk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_cycle_reset", 32'(obs), 32'(exp_word(S_RESET, 8'd0)));
        step_n(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
